// File: rtl/mix_column.sv
// AES MixColumns / InvMixColumns pass, run in place over the shared 32-entry statemt RAM.
// Latency: start accepted in cycle T, ap_done/ap_ready pulse in T+21, back in IDLE at T+22.
// Backpressure: none; ap_start is only sampled in IDLE and ignored while a pass is running.
//
// Ports:
//   ap_clk, ap_rst_n           clock (rising edge), async active-low reset
//   ap_start/done/idle/ready   block-level handshake, ap_ready == ap_done
//   mode                       0 = MixColumns, 1 = InvMixColumns (latched on start)
//   statemt_*0 / statemt_*1    two ports of a 1-cycle-latency dual-port RAM
//
// Build option: define MIX_COLUMN_INV_EN to include the inverse transform.
// Without it, mode is ignored and only the forward transform is built.
module mix_column #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic              mode,
  output logic [ADDR_W-1:0] statemt_address0,
  output logic              statemt_ce0,
  output logic              statemt_we0,
  output logic [DATA_W-1:0] statemt_d0,
  input  logic [DATA_W-1:0] statemt_q0,
  output logic [ADDR_W-1:0] statemt_address1,
  output logic              statemt_ce1,
  output logic              statemt_we1,
  output logic [DATA_W-1:0] statemt_d1,
  input  logic [DATA_W-1:0] statemt_q1
);

  typedef enum logic [2:0] {IDLE, LOOP, RD1, CALC, WR0, WR1} state_t;

  state_t      state;
  logic [2:0]  j;
  logic [7:0]  s0, s1, s2, s3;
  logic [7:0]  r0, r1, r2, r3;
  logic        col_end;
  logic [ADDR_W-1:0] addr_row0, addr_row1, addr_row2, addr_row3;

  // Only the low byte of each RAM word carries state.
  logic unused_q_hi;
  assign unused_q_hi = ^{statemt_q0[DATA_W-1:8], statemt_q1[DATA_W-1:8]};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 2*a ^ 3*b ^ c ^ d
  function automatic logic [7:0] fwd_byte(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
    return xtime(a) ^ xtime(b) ^ b ^ c ^ d;
  endfunction

`ifdef MIX_COLUMN_INV_EN
  logic mode_r;

  // 0E*a ^ 0B*b ^ 0D*c ^ 09*d, each product built from x2/x4/x8 partials.
  function automatic logic [7:0] inv_byte(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
    logic [7:0] a2, a4, a8, b2, b4, b8, c2, c4, c8, d2, d4, d8;
    a2 = xtime(a); a4 = xtime(a2); a8 = xtime(a4);
    b2 = xtime(b); b4 = xtime(b2); b8 = xtime(b4);
    c2 = xtime(c); c4 = xtime(c2); c8 = xtime(c4);
    d2 = xtime(d); d4 = xtime(d2); d8 = xtime(d4);
    return (a8 ^ a4 ^ a2) ^ (b8 ^ b2 ^ b) ^ (c8 ^ c4 ^ c) ^ (d8 ^ d);
  endfunction

  assign r0 = mode_r ? inv_byte(s0, s1, s2, s3) : fwd_byte(s0, s1, s2, s3);
  assign r1 = mode_r ? inv_byte(s1, s2, s3, s0) : fwd_byte(s1, s2, s3, s0);
  assign r2 = mode_r ? inv_byte(s2, s3, s0, s1) : fwd_byte(s2, s3, s0, s1);
  assign r3 = mode_r ? inv_byte(s3, s0, s1, s2) : fwd_byte(s3, s0, s1, s2);
`else
  logic unused_mode;
  assign unused_mode = mode;

  assign r0 = fwd_byte(s0, s1, s2, s3);
  assign r1 = fwd_byte(s1, s2, s3, s0);
  assign r2 = fwd_byte(s2, s3, s0, s1);
  assign r3 = fwd_byte(s3, s0, s1, s2);
`endif

  // j reaches 4 after the last column; that LOOP visit ends the pass.
  assign col_end = (j == 3'd4);

  // Byte (row r, column j) lives at 4j+r; bit 4 of the address is always 0.
  assign addr_row0 = {{(ADDR_W-4){1'b0}}, j[1:0], 2'd0};
  assign addr_row1 = {{(ADDR_W-4){1'b0}}, j[1:0], 2'd1};
  assign addr_row2 = {{(ADDR_W-4){1'b0}}, j[1:0], 2'd2};
  assign addr_row3 = {{(ADDR_W-4){1'b0}}, j[1:0], 2'd3};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
      j     <= 3'd0;
      s0    <= 8'h00;
      s1    <= 8'h00;
      s2    <= 8'h00;
      s3    <= 8'h00;
`ifdef MIX_COLUMN_INV_EN
      mode_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ap_start) begin
            j     <= 3'd0;
            state <= LOOP;
`ifdef MIX_COLUMN_INV_EN
            mode_r <= mode;
`endif
          end
        end
        LOOP: state <= col_end ? IDLE : RD1;
        // Rows 0/1 return now (read issued in LOOP); rows 2/3 are requested.
        RD1: begin
          s0    <= statemt_q0[7:0];
          s1    <= statemt_q1[7:0];
          state <= CALC;
        end
        // Whole column is held before any write, so no read-after-write hazard.
        CALC: begin
          s2    <= statemt_q0[7:0];
          s3    <= statemt_q1[7:0];
          state <= WR0;
        end
        WR0: state <= WR1;
        WR1: begin
          j     <= j + 3'd1;
          state <= LOOP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM controls are decoded from the state register: the RAM samples them at
  // the end of the same cycle, so registering them would add a cycle per access.
  always_comb begin
    statemt_address0 = '0;
    statemt_address1 = '0;
    statemt_ce0      = 1'b0;
    statemt_ce1      = 1'b0;
    statemt_we0      = 1'b0;
    statemt_we1      = 1'b0;
    statemt_d0       = '0;
    statemt_d1       = '0;
    case (state)
      LOOP: begin
        if (!col_end) begin
          statemt_ce0      = 1'b1;
          statemt_ce1      = 1'b1;
          statemt_address0 = addr_row0;
          statemt_address1 = addr_row1;
        end
      end
      RD1: begin
        statemt_ce0      = 1'b1;
        statemt_ce1      = 1'b1;
        statemt_address0 = addr_row2;
        statemt_address1 = addr_row3;
      end
      WR0: begin
        statemt_ce0      = 1'b1;
        statemt_ce1      = 1'b1;
        statemt_we0      = 1'b1;
        statemt_we1      = 1'b1;
        statemt_address0 = addr_row0;
        statemt_address1 = addr_row1;
        statemt_d0       = {{(DATA_W-8){1'b0}}, r0};
        statemt_d1       = {{(DATA_W-8){1'b0}}, r1};
      end
      WR1: begin
        statemt_ce0      = 1'b1;
        statemt_ce1      = 1'b1;
        statemt_we0      = 1'b1;
        statemt_we1      = 1'b1;
        statemt_address0 = addr_row2;
        statemt_address1 = addr_row3;
        statemt_d0       = {{(DATA_W-8){1'b0}}, r2};
        statemt_d1       = {{(DATA_W-8){1'b0}}, r3};
      end
      default: ;
    endcase
  end

  assign ap_done  = (state == LOOP) && col_end;
  assign ap_ready = ap_done;
  assign ap_idle  = (state == IDLE);

endmodule

// File: tb/tb_mix_column.sv
// Self-checking bench for mix_column: behavioural dual-port RAM, GF(2^8) reference model.
// Latency: expects ap_done 21 cycles after the start-accept cycle.
// Backpressure: none; exercises ignored mid-pass starts and back-to-back starts.
module tb_mix_column;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              ap_clk;
  logic              ap_rst_n;
  logic              ap_start;
  logic              ap_done;
  logic              ap_idle;
  logic              ap_ready;
  logic              mode;
  logic [ADDR_W-1:0] address0, address1;
  logic              ce0, ce1, we0, we1;
  logic [DATA_W-1:0] d0, d1, q0, q1;

  mix_column #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .ap_start        (ap_start),
    .ap_done         (ap_done),
    .ap_idle         (ap_idle),
    .ap_ready        (ap_ready),
    .mode            (mode),
    .statemt_address0(address0),
    .statemt_ce0     (ce0),
    .statemt_we0     (we0),
    .statemt_d0      (d0),
    .statemt_q0      (q0),
    .statemt_address1(address1),
    .statemt_ce1     (ce1),
    .statemt_we1     (we1),
    .statemt_d1      (d1),
    .statemt_q1      (q1)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // ---------------- RAM model and monitors ----------------
  logic [31:0] mem      [32];
  logic [31:0] init_mem [32];
  logic [31:0] exp_word [32];
  logic        tb_load;
  int          wr_cnt   [32];
  int          wr_snap  [32];
  int          idle_viol;

  always @(posedge ap_clk) begin
    if (tb_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_mem[i];
    end else begin
      if (ce0) begin
        if (we0) begin
          mem[address0]    <= d0;
          wr_cnt[address0] <= wr_cnt[address0] + 1;
        end else q0 <= mem[address0];
      end
      if (ce1) begin
        if (we1) begin
          mem[address1]    <= d1;
          wr_cnt[address1] <= wr_cnt[address1] + 1;
        end else q1 <= mem[address1];
      end
    end
  end

  initial idle_viol = 0;
  always @(negedge ap_clk) begin
    if (ap_rst_n === 1'b1 && ap_idle === 1'b1 &&
        (ce0 || ce1 || we0 || we1 || (|address0) || (|address1) || (|d0) || (|d1)))
      idle_viol <= idle_viol + 1;
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Column word: row 0 in bits [31:24] ... row 3 in bits [7:0].
  function automatic logic [31:0] mix_ref(input logic [31:0] col, input bit inv);
    logic [7:0] s [4];
    logic [7:0] k [4];
    logic [7:0] acc;
    logic [31:0] res = 32'h0;
    for (int r = 0; r < 4; r++) s[r] = col[31-8*r -: 8];
    if (inv) k = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     k = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int i = 0; i < 4; i++) begin
      acc = 8'h00;
      for (int t = 0; t < 4; t++) acc ^= gmul(k[t], s[(i+t)%4]);
      res[31-8*i -: 8] = acc;
    end
    return res;
  endfunction

  function automatic bit eff_inv(input bit m);
`ifdef MIX_COLUMN_INV_EN
    return m;
`else
    return 1'b0;
`endif
  endfunction

  task automatic apply_model(input int c, input bit m);
    logic [31:0] col, res;
    col = {exp_word[4*c][7:0], exp_word[4*c+1][7:0], exp_word[4*c+2][7:0], exp_word[4*c+3][7:0]};
    res = mix_ref(col, eff_inv(m));
    for (int r = 0; r < 4; r++) exp_word[4*c+r] = {24'h0, res[31-8*r -: 8]};
  endtask

  task automatic apply_all(input bit m);
    for (int c = 0; c < 4; c++) apply_model(c, m);
  endtask

  function automatic logic [31:0] col_of(input int c);
    return {mem[4*c][7:0], mem[4*c+1][7:0], mem[4*c+2][7:0], mem[4*c+3][7:0]};
  endfunction

  task automatic check_mem(input string tag);
    for (int a = 0; a < 32; a++) check($sformatf("%s_a%0d", tag, a), mem[a], exp_word[a]);
  endtask

  task automatic load_cols(input logic [31:0] c0, input logic [31:0] c1,
                           input logic [31:0] c2, input logic [31:0] c3, input bit ones);
    logic [31:0] cols [4];
    logic [23:0] hi;
    logic [7:0]  by;
    cols = '{c0, c1, c2, c3};
    for (int a = 0; a < 32; a++) begin
      hi = ones ? 24'hffffff : 24'($urandom());
      by = (a < 16) ? cols[a/4][31-8*(a%4) -: 8] : 8'($urandom());
      init_mem[a] = {hi, by};
      exp_word[a] = init_mem[a];
    end
    @(negedge ap_clk) tb_load = 1'b1;
    @(negedge ap_clk) tb_load = 1'b0;
  endtask

  task automatic snap_writes();
    for (int a = 0; a < 32; a++) wr_snap[a] = wr_cnt[a];
  endtask

  task automatic check_writes(input string tag, input int mult);
    int bad = 0;
    for (int a = 0; a < 32; a++)
      if (wr_cnt[a] - wr_snap[a] != ((a < 16) ? mult : 0)) bad++;
    check(tag, bad, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_idle"},  {31'b0, ap_idle}, 32'd1);
    check({tag, "_done"},  {30'b0, ap_done, ap_ready}, 32'd0);
    check({tag, "_cewe"},  {28'b0, ce0, ce1, we0, we1}, 32'd0);
    check({tag, "_addr"},  {22'b0, address0, address1}, 32'd0);
    check({tag, "_d0"},    d0, 32'd0);
    check({tag, "_d1"},    d1, 32'd0);
  endtask

  // One pass: start in cycle T, optional extra start pulse in cycle T+pulse_at.
  task automatic run_pass(input string tag, input bit m, input int pulse_at);
    int done_k = -1;
    snap_writes();
    @(negedge ap_clk);
    check({tag, "_idle_pre"}, {31'b0, ap_idle}, 32'd1);
    mode     = m;
    ap_start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge ap_clk);
      ap_start = (k == pulse_at);
      if (ap_done === 1'b1) begin
        done_k = k;
        check({tag, "_ready"}, {31'b0, ap_ready}, 32'd1);
        break;
      end
    end
    ap_start = 1'b0;
    check({tag, "_done_cyc"}, done_k, 32'd21);
    @(negedge ap_clk);
    check({tag, "_idle_post"}, {31'b0, ap_idle}, 32'd1);
    check_writes({tag, "_wr_once"}, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int k1, k2, busy;
    logic idle22, idle23;
    logic [31:0] exp_col;

    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    mode     = 1'b0;
    tb_load  = 1'b0;

    // Reset state
    repeat (3) @(negedge ap_clk);
    check_reset_outputs("rst");
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check_reset_outputs("post_rst");

    // Forward known answers and fixed points
    load_cols(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 1'b0);
    run_pass("kat1", 1'b0, 0);
    apply_all(1'b0);
    check("kat_col0", col_of(0), 32'h8e4da1bc);
    check("kat_col1", col_of(1), 32'h9fdc589d);
    check("fix_01",   col_of(2), 32'h01010101);
    check("fix_c6",   col_of(3), 32'hc6c6c6c6);
    check_mem("kat1");

    // Near-fixed point and upper-bit masking
    load_cols(32'hd4d4d4d5, 32'h2d26314c, $urandom(), $urandom(), 1'b1);
    run_pass("kat2", 1'b0, 0);
    apply_all(1'b0);
    check("kat_d4",  col_of(0), 32'hd5d5d7d6);
    check("mask_w4", mem[4], 32'h0000004d);
    check("mask_w5", mem[5], 32'h0000007e);
    check("mask_w6", mem[6], 32'h000000bd);
    check("mask_w7", mem[7], 32'h000000f8);
    check_mem("kat2");

    // mode=1: inverse when built in, forward otherwise
    load_cols(32'h8e4da1bc, $urandom(), $urandom(), $urandom(), 1'b0);
    run_pass("inv", 1'b1, 0);
`ifdef MIX_COLUMN_INV_EN
    exp_col = 32'hdb135345;
`else
    exp_col = mix_ref(32'h8e4da1bc, 1'b0);
`endif
    check("inv_col0", col_of(0), exp_col);
    apply_all(1'b1);
    check_mem("inv");

    // Start pulse during RD1 must not start a second pass
    load_cols($urandom(), $urandom(), $urandom(), $urandom(), 1'b0);
    run_pass("rd1_pulse", 1'b0, 2);
    busy = 0;
    repeat (6) begin
      @(negedge ap_clk);
      if (ap_idle !== 1'b1) busy++;
    end
    check("rd1_pulse_no_restart", busy, 0);
    apply_all(1'b0);
    check_mem("rd1_pulse");

    // ap_start held high: back-to-back passes, one IDLE cycle between
    load_cols($urandom(), $urandom(), $urandom(), $urandom(), 1'b0);
    snap_writes();
    k1 = -1; k2 = -1; idle22 = 1'bx; idle23 = 1'bx;
    @(negedge ap_clk);
    mode = 1'b0;
    ap_start = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge ap_clk);
      if (k == 22) idle22 = ap_idle;
      if (k == 23) idle23 = ap_idle;
      if (ap_done === 1'b1) begin
        if (k1 < 0) k1 = k;
        else begin
          k2 = k;
          ap_start = 1'b0;
          break;
        end
      end
    end
    ap_start = 1'b0;
    check("b2b_done1", k1, 32'd21);
    check("b2b_gap_idle", {31'b0, idle22}, 32'd1);
    check("b2b_restart", {31'b0, idle23}, 32'd0);
    check("b2b_done2", k2, 32'd43);
    repeat (2) @(negedge ap_clk);
    check("b2b_stop", {31'b0, ap_idle}, 32'd1);
    check_writes("b2b_wr_twice", 2);
    apply_all(1'b0);
    apply_all(1'b0);
    check_mem("b2b");

    // Reset asserted in WR0 of column 2 (cycle T+14)
    load_cols($urandom(), $urandom(), $urandom(), $urandom(), 1'b0);
    @(negedge ap_clk);
    mode = 1'b0;
    ap_start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge ap_clk);
      ap_start = 1'b0;
    end
    check("pre_rst_wr0", {26'b0, we0, address0}, {26'b0, 1'b1, 5'd8});
    ap_rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    apply_model(0, 1'b0);
    apply_model(1, 1'b0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check_mem("mid_rst");
    run_pass("after_rst", 1'b0, 0);
    apply_all(1'b0);
    check_mem("after_rst");

    // Randomized passes, random mode
    for (int p = 0; p < 10; p++) begin
      bit m;
      m = 1'($urandom());
      load_cols($urandom(), $urandom(), $urandom(), $urandom(), 1'($urandom()));
      run_pass($sformatf("rand%0d", p), m, 0);
      apply_all(m);
      check_mem($sformatf("rand%0d", p));
    end

    check("idle_ports_quiet", idle_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
